// File: rtl/serial_bit_source.sv
// Parallel-to-serial front end for the sequence detector: accepts words over valid/ready,
// buffers one word, and shifts them out one bit per clock on x with a fixed idle fill.
module serial_bit_source #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic                     x,
    output logic                     x_valid,
    output logic                     word_done,
    output logic                     busy,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               shifting;
    logic               last_bit;
    logic               xfer;
    logic               out_bit;
    logic [WIDTH-1:0]   sreg_shifted;

    assign shifting  = (state_q == ST_SHIFT);
    assign last_bit  = shifting && (cnt_q == LAST_IDX);
    assign din_ready = !hold_full_q;
    assign xfer      = din_valid && din_ready;

    // The bit on x always sits at the outgoing end of sreg; shifting moves the next one there.
    assign out_bit      = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};

    always_comb begin
        // NOTE: every next-state signal takes its current value first, so no branch can infer a latch.
        state_d     = state_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    sreg_d  = din;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    // Refill from the hold first; a held word blocks din_ready so xfer is 0 here.
                    if (hold_full_q) begin
                        sreg_d      = hold_q;
                        hold_full_d = 1'b0;
                        cnt_d       = '0;
                    end else if (xfer) begin
                        sreg_d = din;
                        cnt_d  = '0;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    sreg_d = sreg_shifted;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (xfer) begin
                        hold_d      = din;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sreg_q      <= '0;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
        end
    end

    // NOTE: the hold data is deliberately not reset; hold_full qualifies it, so stale contents never reach x.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign x         = shifting ? out_bit : IDLE_BIT;
    assign x_valid   = shifting;
    assign word_done = last_bit;
    assign busy      = shifting || hold_full_q;
    assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_serial_bit_source.sv
// Self-checking bench for serial_bit_source: an MSB-first and an LSB-first instance share stimulus
// and are compared each cycle against a queue-of-words reference model.
module tb_serial_bit_source;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;

    logic       a_rdy, a_x, a_xv, a_wd, a_busy;
    logic [2:0] a_cnt;
    logic       b_rdy, b_x, b_xv, b_wd, b_busy;
    logic [2:0] b_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: accepted words in arrival order; front word is the one on x, mpos its bit index.
    logic [7:0] mq[$];
    int         mpos = 0;

    localparam logic [15:0] IDLE_VEC = 16'h8888;

    serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(a_rdy),
        .x(a_x), .x_valid(a_xv), .word_done(a_wd), .busy(a_busy), .bit_cnt(a_cnt)
    );

    serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(b_rdy),
        .x(b_x), .x_valid(b_xv), .word_done(b_wd), .busy(b_busy), .bit_cnt(b_cnt)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        mq.delete();
        mpos = 0;
    endfunction

    function automatic void model_edge();
        bit xfer;
        if (rst !== 1'b1) begin
            model_reset();
            return;
        end
        xfer = (din_valid === 1'b1) && (mq.size() < 2);
        if (mq.size() > 0) begin
            mpos++;
            if (mpos == 8) begin
                void'(mq.pop_front());
                mpos = 0;
            end
        end
        if (xfer) mq.push_back(din);
    endfunction

    function automatic logic [15:0] model_vec();
        logic [7:0] w;
        logic ax, bx, xv, wd, bs, rdy;
        logic [2:0] bc;
        ax = 1'b1; bx = 1'b1; xv = 1'b0; wd = 1'b0; bc = 3'd0;
        bs  = (mq.size() > 0);
        rdy = (mq.size() < 2);
        if (mq.size() > 0) begin
            w  = mq[0];
            ax = w[3'(7 - mpos)];
            bx = w[3'(mpos)];
            xv = 1'b1;
            wd = (mpos == 7);
            bc = 3'(mpos);
        end
        return {ax, xv, wd, bs, rdy, bc, bx, xv, wd, bs, rdy, bc};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {a_x, a_xv, a_wd, a_busy, a_rdy, a_cnt, b_x, b_xv, b_wd, b_busy, b_rdy, b_cnt};
    endfunction

    task automatic tick(input logic v, input logic [7:0] d);
        din_valid = v;
        din       = d;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        rst = 1'b0; din_valid = 1'b0; din = 8'h00;
        model_reset();
        #1;
        obs = dut_vec(); checks++;
        if (obs !== IDLE_VEC) begin errors++; $display("FAIL reset_t0: got %h want %h", obs, IDLE_VEC); end
        for (int c = 0; c < 3; c++) begin
            tick(1'b1, 8'($urandom));
            obs = dut_vec(); checks++;
            if (obs !== IDLE_VEC) begin errors++; $display("FAIL reset_held c%0d: got %h want %h", c, obs, IDLE_VEC); end
        end
        #2 rst = 1'b1;
    endtask

    task automatic test_idle_hold();
        logic [15:0] obs;
        for (int c = 0; c < 20; c++) begin
            tick(1'b0, 8'($urandom));
            obs = dut_vec(); checks++;
            if (obs !== IDLE_VEC) begin errors++; $display("FAIL idle_hold c%0d: got %h want %h", c, obs, IDLE_VEC); end
        end
    endtask

    task automatic test_single_word();
        logic [15:0] obs, exp;
        logic [7:0] seq, wdm;
        logic xv_ok, post_x, post_xv;
        seq = '0; wdm = '0; xv_ok = 1'b1; post_x = 1'b0; post_xv = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 0) tick(1'b1, 8'h4A); else tick(1'b0, 8'($urandom));
            obs = dut_vec(); exp = model_vec(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL single_vec c%0d: got %h want %h", c, obs, exp); end
            if (c < 8) begin
                seq[7-c] = a_x;
                wdm[7-c] = a_wd;
                if (a_xv !== 1'b1) xv_ok = 1'b0;
            end else if (c == 8) begin
                post_x = a_x; post_xv = a_xv;
            end
        end
        checks++;
        if (seq !== 8'h4A) begin errors++; $display("FAIL single_bits: got %b want %b", seq, 8'h4A); end
        checks++;
        if (wdm !== 8'h01) begin errors++; $display("FAIL single_word_done: got %b want %b", wdm, 8'h01); end
        checks++;
        if (xv_ok !== 1'b1) begin errors++; $display("FAIL single_x_valid: got %b want 1", xv_ok); end
        checks++;
        if ({post_x, post_xv} !== 2'b10) begin errors++; $display("FAIL single_after: got %b want 10", {post_x, post_xv}); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] obs, exp, seq, wdm;
        logic xv_ok, rdy_at8;
        int rdy_low;
        seq = '0; wdm = '0; xv_ok = 1'b1; rdy_low = 0; rdy_at8 = 1'b0;
        for (int c = 0; c < 18; c++) begin
            if (c == 0) tick(1'b1, 8'hA5);
            else if (c == 1) tick(1'b1, 8'h3C);
            else tick(1'b0, 8'($urandom));
            obs = dut_vec(); exp = model_vec(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL b2b_vec c%0d: got %h want %h", c, obs, exp); end
            if (c < 16) begin
                seq[15-c] = a_x;
                wdm[15-c] = a_wd;
                if (a_xv !== 1'b1) xv_ok = 1'b0;
            end
            if (c >= 1 && c <= 7 && a_rdy === 1'b0) rdy_low++;
            if (c == 8) rdy_at8 = a_rdy;
        end
        checks++;
        if (seq !== 16'hA53C) begin errors++; $display("FAIL b2b_bits: got %h want %h", seq, 16'hA53C); end
        checks++;
        if (wdm !== 16'h0101) begin errors++; $display("FAIL b2b_word_done: got %b want %b", wdm, 16'h0101); end
        checks++;
        if (xv_ok !== 1'b1) begin errors++; $display("FAIL b2b_x_valid_gap: got %b want 1", xv_ok); end
        checks++;
        if (rdy_low != 7 || rdy_at8 !== 1'b1) begin
            errors++; $display("FAIL b2b_din_ready: low_cycles=%0d ready_at_c8=%b want 7 and 1", rdy_low, rdy_at8);
        end
    endtask

    task automatic test_bypass();
        logic [15:0] obs, exp;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) tick(1'b1, 8'h5A); else tick(1'b0, 8'($urandom));
            obs = dut_vec(); exp = model_vec(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL bypass_vec c%0d: got %h want %h", c, obs, exp); end
        end
        checks++;
        if ({a_wd, a_rdy, a_cnt} !== 5'b11_111) begin
            errors++; $display("FAIL bypass_last_bit: got %b want 11111", {a_wd, a_rdy, a_cnt});
        end
        tick(1'b1, 8'hFF);
        checks++;
        if ({a_x, a_xv, a_wd, a_busy, a_rdy, a_cnt} !== 8'b1101_1000) begin
            errors++; $display("FAIL bypass_first_bit: got %b want 11011000", {a_x, a_xv, a_wd, a_busy, a_rdy, a_cnt});
        end
        for (int c = 0; c < 9; c++) begin
            tick(1'b0, 8'($urandom));
            obs = dut_vec(); exp = model_vec(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL bypass_drain c%0d: got %h want %h", c, obs, exp); end
        end
    endtask

    task automatic test_lsb_first();
        logic [15:0] obs, exp;
        logic [7:0] seq_a, seq_b;
        seq_a = '0; seq_b = '0;
        for (int c = 0; c < 10; c++) begin
            if (c == 0) tick(1'b1, 8'h01); else tick(1'b0, 8'($urandom));
            obs = dut_vec(); exp = model_vec(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL lsb_vec c%0d: got %h want %h", c, obs, exp); end
            if (c < 8) begin
                seq_a[7-c] = a_x;
                seq_b[7-c] = b_x;
            end
        end
        checks++;
        if (seq_b !== 8'b1000_0000) begin errors++; $display("FAIL lsb_first_bits: got %b want 10000000", seq_b); end
        checks++;
        if (seq_a !== 8'b0000_0001) begin errors++; $display("FAIL msb_first_bits: got %b want 00000001", seq_a); end
    endtask

    task automatic test_reset_midword();
        logic [15:0] obs, exp;
        logic [7:0] seq_a, seq_b;
        logic post_xv;
        for (int c = 0; c < 5; c++) begin
            if (c == 0) tick(1'b1, 8'hF0);
            else if (c == 1) tick(1'b1, 8'h99);
            else tick(1'b0, 8'($urandom));
            obs = dut_vec(); exp = model_vec(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL midrst_pre c%0d: got %h want %h", c, obs, exp); end
        end
        #2 rst = 1'b0;
        model_reset();
        #1;
        obs = dut_vec(); checks++;
        if (obs !== IDLE_VEC) begin errors++; $display("FAIL midrst_immediate: got %h want %h", obs, IDLE_VEC); end
        tick(1'b1, 8'($urandom));
        obs = dut_vec(); checks++;
        if (obs !== IDLE_VEC) begin errors++; $display("FAIL midrst_held: got %h want %h", obs, IDLE_VEC); end
        #2 rst = 1'b1;
        seq_a = '0; seq_b = '0; post_xv = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 0) tick(1'b1, 8'h0F); else tick(1'b0, 8'($urandom));
            obs = dut_vec(); exp = model_vec(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL midrst_post c%0d: got %h want %h", c, obs, exp); end
            if (c < 8) begin
                seq_a[7-c] = a_x;
                seq_b[7-c] = b_x;
            end else if (c == 8) begin
                post_xv = a_xv;
            end
        end
        checks++;
        if (seq_a !== 8'h0F || seq_b !== 8'hF0) begin
            errors++; $display("FAIL midrst_new_word: got %h/%h want 0f/f0", seq_a, seq_b);
        end
        checks++;
        if (post_xv !== 1'b0) begin errors++; $display("FAIL midrst_no_remnant: x_valid got %b want 0", post_xv); end
    endtask

    task automatic test_random();
        logic [15:0] obs, exp;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b0;
                model_reset();
                #1;
                obs = dut_vec(); checks++;
                if (obs !== IDLE_VEC) begin errors++; $display("FAIL rand_async_rst c%0d: got %h want %h", c, obs, IDLE_VEC); end
                tick(1'b1, 8'($urandom));
                #2 rst = 1'b1;
            end
            tick(1'($urandom_range(0, 99) < 65), 8'($urandom));
            obs = dut_vec(); exp = model_vec(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL rand_vec c%0d: got %h want %h", c, obs, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_idle_hold();
        test_single_word();
        test_back_to_back();
        test_idle_hold();
        test_bypass();
        test_lsb_first();
        test_reset_midword();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
